// File: rtl/orient_pkg.sv
`default_nettype none
// ============================================================================
// Package  : orient_pkg
// Shared state encoding, Q-format, width and field helpers for
// orientation_math_sweep and orient_trig_lut.
// Revision : 1.0
// ============================================================================
package orient_pkg;

    localparam int c_step_deg_def = 15;
    localparam int c_num_dirs_def = 360 / c_step_deg_def;
    localparam int c_trig_frac    = 7;   // signed Q1.7 trig values

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_PTC   = 3'd2,
        S_DELTA = 3'd3,
        S_SWEEP = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Width of cross/dot: a rotated displacement never exceeds sqrt(2)*|d|,
    // so the two-term sum fits without the extra carry bit.
    function automatic int prod_w(input int r_w, input int trig_frac);
        return r_w + trig_frac + 4;
    endfunction

    // LSB of the radius (is_theta = 0) or theta index (is_theta = 1) field.
    function automatic int fld_lsb(input int r_w, input logic is_theta);
        return is_theta ? r_w : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/orient_trig_lut.sv
`default_nettype none
// ============================================================================
// Module   : orient_trig_lut
// Direction index to signed Q1.TRIG_FRAC sine and cosine (15-degree grid).
// Revision : 1.0
// ============================================================================
module orient_trig_lut
    import orient_pkg::*;
#(
    parameter int ANG_W     = 5,
    parameter int STEP_DEG  = c_step_deg_def,
    parameter int TRIG_FRAC = c_trig_frac
) (
    input  logic [ANG_W-1:0]              i_idx,
    output logic signed [TRIG_FRAC+1:0]   o_sin,
    output logic signed [TRIG_FRAC+1:0]   o_cos
);

    // Folds any angle into the first quadrant; table entries are round(128*sin).
    function automatic logic signed [TRIG_FRAC+1:0] sin_q(input int deg);
        int   d;
        int   a;
        int   m;
        logic neg;
        d   = deg % 360;
        neg = 1'b0;
        if (d <= 90) begin
            a = d;
        end else if (d <= 180) begin
            a = 180 - d;
        end else if (d <= 270) begin
            a   = d - 180;
            neg = 1'b1;
        end else begin
            a   = 360 - d;
            neg = 1'b1;
        end
        case (a)
            0:       m = 0;
            15:      m = 33;
            30:      m = 64;
            45:      m = 91;
            60:      m = 111;
            75:      m = 124;
            90:      m = 128;
            default: m = 0;
        endcase
        m = (m << TRIG_FRAC) >>> 7;
        if (neg) begin
            m = -m;
        end
        return m[TRIG_FRAC+1:0];
    endfunction

    assign o_sin = sin_q(int'(i_idx) * STEP_DEG);
    assign o_cos = sin_q(int'(i_idx) * STEP_DEG + 90);

endmodule
`default_nettype wire

// File: rtl/orientation_math_sweep.sv
`default_nettype none
// ============================================================================
// Module   : orientation_math_sweep
// Heading index between two polar fixes, found by sweeping one candidate
// direction per cycle. Optional macro ORIENT_EARLY_EXIT_EN ends the sweep on
// the first candidate within the no-motion tolerance.
// Revision : 1.0
// ============================================================================
module orientation_math_sweep
    import orient_pkg::*;
#(
    parameter int R_W          = 8,
    parameter int ANG_W        = 5,
    parameter int NUM_DIRS     = c_num_dirs_def,
    parameter int STEP_DEG     = c_step_deg_def,
    parameter int TRIG_FRAC    = c_trig_frac,
    parameter int ERROR_FACTOR = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ANG_W+R_W-1:0]  r_theta_original,
    input  logic [ANG_W+R_W-1:0]  r_theta_final,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ANG_W-1:0]      orientation,
    output logic                  no_motion,
    output logic                  angle_err
);

    localparam int               c_pw    = prod_w(R_W, TRIG_FRAC);
    localparam int               c_tw    = TRIG_FRAC + 2;
    localparam int               c_r_lsb = fld_lsb(R_W, 1'b0);
    localparam int               c_t_lsb = fld_lsb(R_W, 1'b1);
    localparam logic [ANG_W:0]   c_ndirs = (ANG_W+1)'(NUM_DIRS);
    localparam logic [ANG_W:0]   c_half  = (ANG_W+1)'(NUM_DIRS / 2);
    localparam logic [ANG_W-1:0] c_last  = ANG_W'(NUM_DIRS - 1);
    localparam logic [R_W+1:0]   c_eps   = (R_W+2)'(ERROR_FACTOR);

    state_t                   r_state, w_next;
    logic [R_W-1:0]           r_r_org, r_r_fin;
    logic [ANG_W-1:0]         r_th_org, r_th_fin, r_d, r_best_idx, r_orient, w_pick;
    logic signed [R_W:0]      r_x_org, r_y_org, r_x_fin, r_y_fin;
    logic signed [R_W+1:0]    r_dx, r_dy, w_dx, w_dy;
    logic [R_W+1:0]           w_dx_abs, w_dy_abs;
    logic [c_pw-1:0]          r_best_err, w_cross_abs;
    logic signed [c_pw-1:0]   w_cross, w_dot, w_dx_e, w_dy_e, w_cos_e, w_sin_e;
    logic signed [c_tw-1:0]   w_sin_org, w_cos_org, w_sin_fin, w_cos_fin, w_sin_d, w_cos_d;
    logic                     r_out_valid, r_no_motion, r_angle_err;
    logic                     w_ang_bad, w_same_th, w_small, w_dot_pos, w_take;
    logic                     w_last, w_sweep_end;

    orient_trig_lut #(.ANG_W(ANG_W), .STEP_DEG(STEP_DEG), .TRIG_FRAC(TRIG_FRAC)) u_lut_org (
        .i_idx (r_th_org),
        .o_sin (w_sin_org),
        .o_cos (w_cos_org)
    );

    orient_trig_lut #(.ANG_W(ANG_W), .STEP_DEG(STEP_DEG), .TRIG_FRAC(TRIG_FRAC)) u_lut_fin (
        .i_idx (r_th_fin),
        .o_sin (w_sin_fin),
        .o_cos (w_cos_fin)
    );

    orient_trig_lut #(.ANG_W(ANG_W), .STEP_DEG(STEP_DEG), .TRIG_FRAC(TRIG_FRAC)) u_lut_d (
        .i_idx (r_d),
        .o_sin (w_sin_d),
        .o_cos (w_cos_d)
    );

    // floor(r * trig / 2^TRIG_FRAC); the product always fits, so a slice is exact.
    function automatic logic signed [R_W:0] to_cart(input logic [R_W-1:0] r,
                                                    input logic signed [c_tw-1:0] t);
        logic signed [R_W+c_tw-1:0] p;
        p = $signed({{c_tw{1'b0}}, r}) * $signed({{R_W{t[c_tw-1]}}, t});
        return p[TRIG_FRAC +: R_W+1];
    endfunction

    function automatic logic [ANG_W-1:0] opposite(input logic [ANG_W-1:0] th);
        logic [ANG_W:0] s;
        s = {1'b0, th} + c_half;
        if (s >= c_ndirs) begin
            s = s - c_ndirs;
        end
        return s[ANG_W-1:0];
    endfunction

    assign w_ang_bad = ({1'b0, r_th_org} >= c_ndirs) || ({1'b0, r_th_fin} >= c_ndirs);
    assign w_same_th = (r_th_org == r_th_fin);

    assign w_dx     = {r_x_fin[R_W], r_x_fin} - {r_x_org[R_W], r_x_org};
    assign w_dy     = {r_y_fin[R_W], r_y_fin} - {r_y_org[R_W], r_y_org};
    assign w_dx_abs = w_dx[R_W+1] ? -w_dx : w_dx;
    assign w_dy_abs = w_dy[R_W+1] ? -w_dy : w_dy;
    assign w_small  = (w_dx_abs <= c_eps) && (w_dy_abs <= c_eps);

    assign w_dx_e  = {{(c_pw-R_W-2){r_dx[R_W+1]}}, r_dx};
    assign w_dy_e  = {{(c_pw-R_W-2){r_dy[R_W+1]}}, r_dy};
    assign w_cos_e = {{(c_pw-c_tw){w_cos_d[c_tw-1]}}, w_cos_d};
    assign w_sin_e = {{(c_pw-c_tw){w_sin_d[c_tw-1]}}, w_sin_d};

    assign w_cross     = (w_dy_e * w_cos_e) - (w_dx_e * w_sin_e);
    assign w_dot       = (w_dx_e * w_cos_e) + (w_dy_e * w_sin_e);
    assign w_cross_abs = w_cross[c_pw-1] ? -w_cross : w_cross;
    assign w_dot_pos   = !w_dot[c_pw-1] && (w_dot != '0);
    assign w_take      = w_dot_pos && (w_cross_abs < r_best_err);
    assign w_last      = (r_d == c_last);

`ifdef ORIENT_EARLY_EXIT_EN
    localparam logic [c_pw-1:0] c_tol = c_pw'(ERROR_FACTOR << TRIG_FRAC);
    logic w_hit;
    assign w_hit       = w_dot_pos && (w_cross_abs <= c_tol);
    assign w_sweep_end = w_last || w_hit;
    assign w_pick      = (w_hit || w_take) ? r_d : r_best_idx;
`else
    assign w_sweep_end = w_last;
    assign w_pick      = w_take ? r_d : r_best_idx;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_CHECK;
            S_CHECK: w_next = (w_ang_bad || w_same_th) ? S_DONE : S_PTC;
            S_PTC:   w_next = S_DELTA;
            S_DELTA: w_next = w_small ? S_DONE : S_SWEEP;
            S_SWEEP: if (w_sweep_end) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_r_org     <= '0;
            r_r_fin     <= '0;
            r_th_org    <= '0;
            r_th_fin    <= '0;
            r_x_org     <= '0;
            r_y_org     <= '0;
            r_x_fin     <= '0;
            r_y_fin     <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_d         <= '0;
            r_best_idx  <= '0;
            r_best_err  <= '1;
            r_orient    <= '0;
            r_out_valid <= 1'b0;
            r_no_motion <= 1'b0;
            r_angle_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_r_org  <= r_theta_original[c_r_lsb +: R_W];
                        r_th_org <= r_theta_original[c_t_lsb +: ANG_W];
                        r_r_fin  <= r_theta_final[c_r_lsb +: R_W];
                        r_th_fin <= r_theta_final[c_t_lsb +: ANG_W];
                    end
                end
                S_CHECK: begin
                    if (w_ang_bad) begin
                        r_angle_err <= 1'b1;
                        r_orient    <= '0;
                        r_out_valid <= 1'b1;
                    end else if (w_same_th) begin
                        r_out_valid <= 1'b1;
                        if (r_r_fin == r_r_org) begin
                            r_no_motion <= 1'b1;
                            r_orient    <= '0;
                        end else if (r_r_fin > r_r_org) begin
                            r_orient <= r_th_org;
                        end else begin
                            r_orient <= opposite(r_th_org);
                        end
                    end
                end
                S_PTC: begin
                    r_x_org <= to_cart(r_r_org, w_cos_org);
                    r_y_org <= to_cart(r_r_org, w_sin_org);
                    r_x_fin <= to_cart(r_r_fin, w_cos_fin);
                    r_y_fin <= to_cart(r_r_fin, w_sin_fin);
                end
                S_DELTA: begin
                    r_dx       <= w_dx;
                    r_dy       <= w_dy;
                    r_best_err <= '1;
                    r_best_idx <= '0;
                    r_d        <= '0;
                    if (w_small) begin
                        r_no_motion <= 1'b1;
                        r_orient    <= '0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (w_take) begin
                        r_best_err <= w_cross_abs;
                        r_best_idx <= r_d;
                    end
                    r_d <= r_d + ANG_W'(1);
                    if (w_sweep_end) begin
                        r_orient    <= w_pick;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_no_motion <= 1'b0;
                        r_angle_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = r_out_valid;
    assign orientation = r_orient;
    assign no_motion   = r_no_motion;
    assign angle_err   = r_angle_err;

endmodule
`default_nettype wire

// File: tb/tb_orientation_math_sweep.sv
`default_nettype none
// ============================================================================
// Module   : tb_orientation_math_sweep
// Directed and random transactions against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_orientation_math_sweep;

    localparam int c_nd = 24;
    localparam int c_ef = 4;

    logic        clock            = 1'b0;
    logic        reset_n          = 1'b0;
    logic        in_valid         = 1'b0;
    logic        out_ready        = 1'b0;
    logic [12:0] r_theta_original = '0;
    logic [12:0] r_theta_final    = '0;
    logic        in_ready, out_valid, no_motion, angle_err;
    logic [4:0]  orientation;

    int n_vec = 0;
    int n_bad = 0;
    int sin_t[c_nd];
    int cos_t[c_nd];

    orientation_math_sweep dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .r_theta_original (r_theta_original),
        .r_theta_final    (r_theta_final),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .orientation      (orientation),
        .no_motion        (no_motion),
        .angle_err        (angle_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int fdiv128(input int p);
        int q;
        q = p / 128;
        if (p < 0 && q * 128 != p) q = q - 1;
        return q;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Heading reference: Cartesian displacement, then nearest grid direction by angle.
    task automatic model(input int ro, input int ko, input int rf, input int kf,
                         output int e_or, output int e_nm, output int e_ae, output int e_lat);
        int dx, dy, cr, dt, best, bestc;
        e_or = 0; e_nm = 0; e_ae = 0; e_lat = 0;
        if (ko >= c_nd || kf >= c_nd) begin
            e_ae = 1; e_lat = 1;
        end else if (ko == kf) begin
            e_lat = 1;
            if (rf == ro)     e_nm = 1;
            else if (rf > ro) e_or = ko;
            else              e_or = (ko + c_nd / 2) % c_nd;
        end else begin
            dx = fdiv128(rf * cos_t[kf]) - fdiv128(ro * cos_t[ko]);
            dy = fdiv128(rf * sin_t[kf]) - fdiv128(ro * sin_t[ko]);
            if (iabs(dx) <= c_ef && iabs(dy) <= c_ef) begin
                e_nm = 1; e_lat = 3;
            end else begin
                best = 0; bestc = 32'h7fffffff; e_lat = 3 + c_nd;
                for (int d = 0; d < c_nd; d++) begin
                    cr = dy * cos_t[d] - dx * sin_t[d];
                    dt = dx * cos_t[d] + dy * sin_t[d];
`ifdef ORIENT_EARLY_EXIT_EN
                    if (dt > 0 && iabs(cr) <= (c_ef * 128) && e_lat == 3 + c_nd) begin
                        best = d; e_lat = 4 + d; bestc = -1;
                    end
`endif
                    if (dt > 0 && iabs(cr) < bestc) begin
                        bestc = iabs(cr); best = d;
                    end
                end
                e_or = best;
            end
        end
    endtask

    task automatic send(input int ro, input int ko, input int rf, input int kf);
        @(negedge clock);
        chk("in_ready_idle", in_ready, 1);
        r_theta_original = {5'(ko), 8'(ro)};
        r_theta_final    = {5'(kf), 8'(rf)};
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input int e_or, input int e_nm, input int e_ae, input int e_lat,
                           input int hold);
        int lat;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("latency", lat, e_lat);
        chk("orientation", orientation, e_or);
        chk("no_motion", no_motion, e_nm);
        chk("angle_err", angle_err, e_ae);
        chk("in_ready_busy", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            r_theta_original = 13'($urandom);
            @(posedge clock);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_orientation", orientation, e_or);
            chk("hold_flags", {no_motion, angle_err}, {e_nm[0], e_ae[0]});
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        chk("release_orientation", orientation, e_or);
    endtask

    task automatic run(input int ro, input int ko, input int rf, input int kf, input int hold);
        int e_or, e_nm, e_ae, e_lat;
        model(ro, ko, rf, kf, e_or, e_nm, e_ae, e_lat);
        send(ro, ko, rf, kf);
        collect(e_or, e_nm, e_ae, e_lat, hold);
    endtask

    initial begin
        real v;
        int  ro, ko, rf, kf;
        for (int k = 0; k < c_nd; k++) begin
            v = 128.0 * $sin(k * 15.0 * 3.14159265358979 / 180.0);
            sin_t[k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
            v = 128.0 * $cos(k * 15.0 * 3.14159265358979 / 180.0);
            cos_t[k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        end

        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_orientation", orientation, 0);
        chk("rst_flags", {no_motion, angle_err}, 0);
        @(negedge clock);
        reset_n = 1'b1;

        run(0, 0, 100, 2, 0);
        run(100, 6, 100, 18, 0);
        run(80, 4, 30, 4, 0);
        run(30, 4, 80, 4, 0);
        run(2, 0, 2, 12, 0);
        run(50, 25, 60, 3, 0);
        run(40, 7, 40, 7, 0);
        run(100, 6, 100, 18, 5);

        // Asynchronous abort during the sweep (or after an early-exit result).
        send(0, 0, 100, 2);
        repeat (13) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clock);
        reset_n = 1'b1;
        run(0, 0, 100, 2, 1);

        // Asynchronous abort while a result is being held.
        send(80, 4, 30, 4);
        @(posedge clock);
        #1;
        chk("pre_abort_valid", out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_done_valid", out_valid, 0);
        chk("abort_done_in_ready", in_ready, 1);
        chk("abort_done_orientation", orientation, 0);
        @(negedge clock);
        reset_n = 1'b1;
        run(30, 4, 80, 4, 0);

        for (int t = 0; t < 40; t++) begin
            ro = int'($urandom_range(0, 255));
            rf = int'($urandom_range(0, 255));
            ko = ($urandom_range(0, 9) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23));
            kf = ($urandom_range(0, 9) == 0) ? ko : int'($urandom_range(0, 23));
            run(ro, ko, rf, kf, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
